ga22_sprite_sched: RTL and testbench

Per-line sprite scheduler for the GA22 double line buffer. During each line it walks the object attribute list for the line being prepared and range-tests every entry against that line. For each hit it fetches one 64-bit tile row from sprite ROM, then issues a single draw write (`lb_we`) to the double line buffer whenever the buffer reports idle. It also owns `scan_toggle`, so buffer swap and list walk stay in lockstep.

---
 rtl/ga22_sprite_sched.sv | 204 ++++++++++++++++++++
 tb/tb_ga22_sprite_sched.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ga22_sprite_sched.sv
// GA22 per-line sprite scheduler: walks the object list for the line being prepared,
// fetches one ROM tile row per hit and issues a single draw write to the double line buffer.
module ga22_sprite_sched #(
  parameter int OBJ_AW       = 7,
  parameter int MAX_PER_LINE = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              line_start,
  input  logic [8:0]        line,
  output logic [OBJ_AW-1:0] obj_addr,
  input  logic [63:0]       obj_data,
  output logic              rom_req,
  output logic [19:0]       rom_addr,
  input  logic              rom_ack,
  input  logic [63:0]       rom_data,
  output logic [63:0]       lb_bitplanes,
  output logic              lb_flip,
  output logic [6:0]        lb_color,
  output logic              lb_prio,
  output logic [9:0]        lb_pos,
  output logic              lb_we,
  input  logic              lb_idle,
  output logic              scan_toggle,
  output logic              busy,
  output logic              overrun,
  output logic [2:0]        dbg_state
);

  // Handshakes: rom_req stays high with a stable rom_addr until the cycle rom_ack is seen;
  // lb_we is a one-cycle strobe issued only after lb_idle was sampled high.
  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CHECK, S_FETCH, S_WRITE, S_NEXT, S_DRAIN
  } state_t;

  localparam int HW = $clog2(MAX_PER_LINE + 1);
  localparam logic [OBJ_AW-1:0] LAST_IDX = '1;
  localparam logic [HW-1:0]     MAX_HITS = HW'(MAX_PER_LINE);

  state_t            r_state;
  logic [8:0]        r_line;
  logic [OBJ_AW-1:0] r_idx;
  logic [HW-1:0]     r_hits;
  logic              r_busy;
  logic              r_scan;
  logic              r_overrun;
  logic              r_rom_req;
  logic [19:0]       r_rom_addr;
  logic [63:0]       r_data;
  logic [9:0]        r_x;
  logic [6:0]        r_color;
  logic              r_prio;
  logic              r_flipx;
  logic [63:0]       r_lb_bitplanes;
  logic              r_lb_flip;
  logic [6:0]        r_lb_color;
  logic              r_lb_prio;
  logic [9:0]        r_lb_pos;
  logic              r_lb_we;

  logic [8:0]  w_y;
  logic [1:0]  w_hcode;
  logic        w_enable;
  logic [15:0] w_code;
  logic        w_flipy;
  logic [8:0]  w_rel;
  logic [7:0]  w_height;
  logic        w_hit;
  logic [7:0]  w_row_full;
  logic [6:0]  w_row;
  logic [15:0] w_code_sum;
  logic        w_unused;

  assign w_y        = obj_data[8:0];
  assign w_hcode    = obj_data[10:9];
  assign w_enable   = obj_data[11];
  assign w_code     = obj_data[27:12];
  assign w_flipy    = obj_data[47];
  // Modulo-512 distance makes sprites that start near the bottom wrap onto the top lines.
  assign w_rel      = r_line - w_y;
  assign w_height   = 8'd16 << w_hcode;
  assign w_hit      = w_enable && (w_rel < {1'b0, w_height});
  assign w_row_full = w_height - 8'd1 - w_rel[7:0];
  assign w_row      = w_flipy ? w_row_full[6:0] : w_rel[6:0];
  assign w_code_sum = w_code + {13'd0, w_row[6:4]};
  assign w_unused   = ^{obj_data[63:48], w_row_full[7]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_line         <= '0;
      r_idx          <= '0;
      r_hits         <= '0;
      r_busy         <= 1'b0;
      r_scan         <= 1'b0;
      r_overrun      <= 1'b0;
      r_rom_req      <= 1'b0;
      r_rom_addr     <= '0;
      r_data         <= '0;
      r_x            <= '0;
      r_color        <= '0;
      r_prio         <= 1'b0;
      r_flipx        <= 1'b0;
      r_lb_bitplanes <= '0;
      r_lb_flip      <= 1'b0;
      r_lb_color     <= '0;
      r_lb_prio      <= 1'b0;
      r_lb_pos       <= '0;
      r_lb_we        <= 1'b0;
    end else begin
      r_lb_we   <= 1'b0;
      r_overrun <= 1'b0;
      if (line_start && r_busy) begin
        r_overrun <= 1'b1;
        r_scan    <= ~r_scan;
        r_line    <= line;
        r_idx     <= '0;
        r_hits    <= '0;
        // An outstanding ROM request must still be acknowledged; its data is thrown away.
        if (r_rom_req && !rom_ack) begin
          r_state <= S_DRAIN;
        end else begin
          r_rom_req <= 1'b0;
          r_state   <= S_READ;
        end
      end else if (line_start) begin
        r_scan  <= ~r_scan;
        r_line  <= line;
        r_idx   <= '0;
        r_hits  <= '0;
        r_busy  <= 1'b1;
        r_state <= S_READ;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_IDLE;
          S_READ: r_state <= S_CHECK;
          S_CHECK: begin
            if (w_hit) begin
              r_x        <= obj_data[37:28];
              r_color    <= obj_data[44:38];
              r_prio     <= obj_data[45];
              r_flipx    <= obj_data[46];
              r_rom_addr <= {w_code_sum, w_row[3:0]};
              r_rom_req  <= 1'b1;
              r_state    <= S_FETCH;
            end else begin
              r_state <= S_NEXT;
            end
          end
          S_FETCH: begin
            if (rom_ack) begin
              r_rom_req <= 1'b0;
              r_data    <= rom_data;
              r_state   <= S_WRITE;
            end
          end
          S_WRITE: begin
            if (lb_idle) begin
              r_lb_we        <= 1'b1;
              r_lb_bitplanes <= r_data;
              r_lb_flip      <= r_flipx;
              r_lb_color     <= r_color;
              r_lb_prio      <= r_prio;
              r_lb_pos       <= r_x;
              r_hits         <= r_hits + HW'(1);
              r_state        <= S_NEXT;
            end
          end
          S_NEXT: begin
            if (r_idx == LAST_IDX || r_hits == MAX_HITS) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_idx   <= r_idx + OBJ_AW'(1);
              r_state <= S_READ;
            end
          end
          S_DRAIN: begin
            if (rom_ack) begin
              r_rom_req <= 1'b0;
              r_state   <= S_READ;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign obj_addr     = r_idx;
  assign rom_req      = r_rom_req;
  assign rom_addr     = r_rom_addr;
  assign lb_bitplanes = r_lb_bitplanes;
  assign lb_flip      = r_lb_flip;
  assign lb_color     = r_lb_color;
  assign lb_prio      = r_lb_prio;
  assign lb_pos       = r_lb_pos;
  assign lb_we        = r_lb_we;
  assign scan_toggle  = r_scan;
  assign busy         = r_busy;
  assign overrun      = r_overrun;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_ga22_sprite_sched.sv
// Directed bench for ga22_sprite_sched: table of single-entry lines plus hand-written
// sequences for backpressure, per-line limit, overrun mid-fetch and asynchronous reset.
module tb_ga22_sprite_sched;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        line_start = 1'b0;
  logic [8:0]  line = '0;
  logic [6:0]  obj_addr;
  logic [63:0] obj_data = '0;
  logic        rom_req;
  logic [19:0] rom_addr;
  logic        rom_ack = 1'b0;
  logic [63:0] rom_data = '0;
  logic [63:0] lb_bitplanes;
  logic        lb_flip;
  logic [6:0]  lb_color;
  logic        lb_prio;
  logic [9:0]  lb_pos;
  logic        lb_we;
  logic        lb_idle = 1'b1;
  logic        scan_toggle;
  logic        busy;
  logic        overrun;
  logic [2:0]  dbg_state;

  ga22_sprite_sched #(.OBJ_AW(7), .MAX_PER_LINE(32)) dut (
    .clk(clk), .reset_n(reset_n), .line_start(line_start), .line(line),
    .obj_addr(obj_addr), .obj_data(obj_data),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
    .lb_bitplanes(lb_bitplanes), .lb_flip(lb_flip), .lb_color(lb_color),
    .lb_prio(lb_prio), .lb_pos(lb_pos), .lb_we(lb_we), .lb_idle(lb_idle),
    .scan_toggle(scan_toggle), .busy(busy), .overrun(overrun), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- environment models ----------------
  logic [63:0] obj_mem [128];
  int          rom_lat = 2;
  logic        rom_en = 1'b1;
  int          rom_cnt = 0;
  logic        force_low = 1'b0;
  int          idle_hold = 0;

  always @(posedge clk) obj_data <= obj_mem[obj_addr];

  function automatic logic [63:0] pat(input logic [19:0] a);
    return {a, 12'hA5C, ~a, 12'h3C5};
  endfunction

  function automatic logic [63:0] mk_obj(input logic [8:0] y, input logic [1:0] hc,
      input logic en, input logic [15:0] code, input logic [9:0] x, input logic [6:0] color,
      input logic prio, input logic flipx, input logic flipy);
    return {16'd0, flipy, flipx, prio, color, x, code, en, hc, y};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      rom_ack = 1'b0;
      if (!rom_req) rom_cnt = 0;
      else if (rom_en) begin
        rom_cnt++;
        if (rom_cnt >= rom_lat) begin
          rom_ack  = 1'b1;
          rom_data = pat(rom_addr);
          rom_cnt  = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (lb_we) idle_hold = 2;
      else if (idle_hold > 0) idle_hold--;
      lb_idle = !force_low && (idle_hold == 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [82:0] exp_q [$];
  logic [82:0] act_q [$];
  logic [19:0] addr_q [$];
  int          we_cyc_q [$];
  int cyc = 0, we_cnt = 0, req_cnt = 0, ovr_cnt = 0;
  int b2b_err = 0, idle_err = 0, stab_err = 0;
  logic prev_we = 1'b0, prev_req = 1'b0;
  logic [19:0] prev_addr = '0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset_n) begin
        cyc++;
        if (lb_we) begin
          we_cnt++;
          we_cyc_q.push_back(cyc);
          act_q.push_back({lb_flip, lb_color, lb_prio, lb_pos, lb_bitplanes});
          if (prev_we) b2b_err++;
          if (!lb_idle) idle_err++;
        end
        if (rom_req && prev_req && rom_addr != prev_addr) stab_err++;
        if (rom_req && !prev_req) begin
          req_cnt++;
          addr_q.push_back(rom_addr);
        end
        if (overrun) ovr_cnt++;
        prev_we   = lb_we;
        prev_req  = rom_req;
        prev_addr = rom_addr;
      end else begin
        prev_we  = 1'b0;
        prev_req = 1'b0;
      end
    end
  end

  int   n_checks = 0;
  int   n_fail = 0;
  logic exp_scan = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_mem();
    for (int i = 0; i < 128; i++) obj_mem[i] = 64'd0;
  endtask

  task automatic do_line(input logic [8:0] l);
    @(negedge clk);
    line_start = 1'b1;
    line       = l;
    exp_scan   = ~exp_scan;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic wait_walk(input string name, output int n);
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 1'b0);
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!rom_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, rom_req, 1'b1);
  endtask

  task automatic check_zero_outputs(input string name);
    check(name, {rom_req, rom_addr, obj_addr, lb_we, lb_bitplanes, lb_flip, lb_color, lb_prio,
                 lb_pos, scan_toggle, busy, overrun, dbg_state}, '0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [6:0]  idx;
    logic [8:0]  line;
    logic [8:0]  y;
    logic [1:0]  hc;
    logic        flipy;
    logic [15:0] code;
    logic [9:0]  x;
    logic [6:0]  color;
    logic        prio;
    logic        flipx;
    logic        en;
    logic        hit;
    logic [19:0] addr;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int   n;
    int   w0, r0, o0;
    logic [82:0] got;
    logic [82:0] want;
    logic [19:0] got_addr;

    vecs[0] = '{7'd0,   9'd40,  9'd32,  2'd0, 1'b0, 16'h0100, 10'd100,  7'd5,    1'b0, 1'b0, 1'b1, 1'b1, 20'h01008};
    vecs[1] = '{7'd3,   9'd12,  9'd10,  2'd2, 1'b1, 16'h0200, 10'd300,  7'h7F,   1'b1, 1'b1, 1'b1, 1'b1, 20'h0203D};
    vecs[2] = '{7'd127, 9'd4,   9'd500, 2'd1, 1'b0, 16'h0010, 10'd1023, 7'h2A,   1'b0, 1'b1, 1'b1, 1'b1, 20'h00110};
    vecs[3] = '{7'd5,   9'd20,  9'd500, 2'd1, 1'b0, 16'h0010, 10'd7,    7'd3,    1'b0, 1'b0, 1'b1, 1'b0, 20'h00000};
    vecs[4] = '{7'd0,   9'd40,  9'd32,  2'd0, 1'b0, 16'h0100, 10'd100,  7'd5,    1'b0, 1'b0, 1'b0, 1'b0, 20'h00000};
    vecs[5] = '{7'd64,  9'd127, 9'd0,   2'd3, 1'b0, 16'hFFFE, 10'd0,    7'd1,    1'b1, 1'b0, 1'b1, 1'b1, 20'h0005F};
    vecs[6] = '{7'd1,   9'd16,  9'd0,   2'd0, 1'b0, 16'h0300, 10'd8,    7'd9,    1'b0, 1'b0, 1'b1, 1'b0, 20'h00000};
    vecs[7] = '{7'd2,   9'd15,  9'd0,   2'd0, 1'b1, 16'hABCD, 10'd512,  7'h40,   1'b1, 1'b0, 1'b1, 1'b1, 20'hABCD0};

    clear_mem();
    repeat (3) @(negedge clk);
    check_zero_outputs("reset_outputs");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_zero_outputs("idle_after_reset");

    // single-entry lines from the table
    rom_lat = 3;
    for (int v = 0; v < 8; v++) begin
      clear_mem();
      obj_mem[vecs[v].idx] = mk_obj(vecs[v].y, vecs[v].hc, vecs[v].en, vecs[v].code, vecs[v].x,
                                    vecs[v].color, vecs[v].prio, vecs[v].flipx, vecs[v].flipy);
      addr_q.delete();
      act_q.delete();
      exp_q.delete();
      if (vecs[v].hit)
        exp_q.push_back({vecs[v].flipx, vecs[v].color, vecs[v].prio, vecs[v].x, pat(vecs[v].addr)});
      r0 = req_cnt;
      w0 = we_cnt;
      do_line(vecs[v].line);
      check($sformatf("v%0d_scan_toggle", v), scan_toggle, exp_scan);
      check($sformatf("v%0d_first_obj_addr", v), obj_addr, 7'd0);
      check($sformatf("v%0d_busy_set", v), busy, 1'b1);
      wait_walk($sformatf("v%0d_walk_done", v), n);
      check($sformatf("v%0d_rom_reqs", v), req_cnt - r0, vecs[v].hit);
      check($sformatf("v%0d_writes", v), we_cnt - w0, vecs[v].hit);
      if (vecs[v].hit) begin
        got_addr = (addr_q.size() > 0) ? addr_q.pop_front() : 'x;
        check($sformatf("v%0d_rom_addr", v), got_addr, vecs[v].addr);
        got  = (act_q.size() > 0) ? act_q.pop_front() : 'x;
        want = exp_q.pop_front();
        check($sformatf("v%0d_write_data", v), got, want);
      end else begin
        check($sformatf("v%0d_miss_walk_cycles", v), n, 384);
      end
    end

    // backpressure: two hits, buffer held busy for 20 cycles
    clear_mem();
    obj_mem[0] = mk_obj(9'd50, 2'd0, 1'b1, 16'h1000, 10'd11, 7'd2, 1'b0, 1'b0, 1'b0);
    obj_mem[5] = mk_obj(9'd50, 2'd0, 1'b1, 16'h2000, 10'd22, 7'd3, 1'b1, 1'b0, 1'b0);
    rom_lat = 2;
    we_cyc_q.delete();
    act_q.delete();
    w0 = we_cnt;
    force_low = 1'b1;
    do_line(9'd50);
    repeat (20) @(negedge clk);
    check("bp_no_write_while_low", we_cnt - w0, 0);
    force_low = 1'b0;
    n = cyc;
    wait_walk("bp_walk_done", o0);
    check("bp_writes", we_cnt - w0, 2);
    if (we_cyc_q.size() == 2) begin
      check("bp_first_after_release", we_cyc_q[0] > n, 1'b1);
      check("bp_gap", (we_cyc_q[1] - we_cyc_q[0]) >= 2, 1'b1);
      check("bp_second_data", act_q[1], {1'b0, 7'd3, 1'b1, 10'd22, pat(20'h20000)});
    end else begin
      check("bp_write_queue", we_cyc_q.size(), 2);
    end

    // per-line limit: 40 hits, only 32 drawn
    clear_mem();
    for (int i = 0; i < 40; i++)
      obj_mem[i] = mk_obj(9'd100, 2'd0, 1'b1, 16'(i), 10'(i), 7'd1, 1'b0, 1'b0, 1'b0);
    rom_lat = 1;
    w0 = we_cnt;
    r0 = req_cnt;
    do_line(9'd100);
    wait_walk("limit_walk_done", n);
    check("limit_writes", we_cnt - w0, 32);
    check("limit_rom_reqs", req_cnt - r0, 32);
    check("limit_last_index", obj_addr, 7'd31);

    // overrun while a ROM request is outstanding
    clear_mem();
    obj_mem[0] = mk_obj(9'd32, 2'd0, 1'b1, 16'h0100, 10'd100, 7'd5, 1'b0, 1'b0, 1'b0);
    rom_lat = 2;
    rom_en  = 1'b0;
    w0 = we_cnt;
    r0 = req_cnt;
    o0 = ovr_cnt;
    do_line(9'd40);
    wait_req("ovr_req_seen");
    do_line(9'd300);
    check("ovr_pulse", overrun, 1'b1);
    check("ovr_scan_toggle", scan_toggle, exp_scan);
    check("ovr_restart_addr", obj_addr, 7'd0);
    check("ovr_req_held", rom_req, 1'b1);
    repeat (3) @(negedge clk);
    check("ovr_pulse_single", overrun, 1'b0);
    check("ovr_req_still_held", rom_req, 1'b1);
    rom_en = 1'b1;
    wait_walk("ovr_walk_done", n);
    check("ovr_no_write", we_cnt - w0, 0);
    check("ovr_single_req", req_cnt - r0, 1);
    check("ovr_count", ovr_cnt - o0, 1);

    // global handshake invariants across everything above
    check("no_back_to_back_we", b2b_err, 0);
    check("we_only_when_idle", idle_err, 0);
    check("rom_addr_stable", stab_err, 0);

    // asynchronous reset mid-handshake
    rom_en = 1'b0;
    do_line(9'd40);
    wait_req("rst_req_seen");
    reset_n = 1'b0;
    #1;
    check_zero_outputs("async_reset_outputs");
    @(negedge clk);
    reset_n  = 1'b1;
    exp_scan = 1'b0;
    rom_en   = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {busy, rom_req, scan_toggle}, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
